// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off; element 15 listed first.
  localparam logic [15:0][7:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG_TABLE[nibble][6:0];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with inter-digit blanking and tear-free display shadow.
// Optional leading-zero suppression: define SEG7_LEADING_ZERO_SUPPRESS_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int IDX_WIDTH    = 2,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SCAN_TICK,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    FRAME_DONE
);

  state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [3:0]              blank_cnt_q, blank_cnt_d;
  logic                    first_q, first_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              hex_q, hex_d;
  logic                    frame_done_q, frame_done_d;

  logic                    enter_drive;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    blank_cnt_d  = blank_cnt_q;
    first_d      = first_q;
    enter_drive  = 1'b0;
    case (state_q)
      IDLE, DRIVE: begin
        if (SCAN_TICK) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
        end
      end
      BLANK: begin
        if (blank_cnt_q == 4'(BLANK_CYCLES - 1)) begin
          state_d     = DRIVE;
          enter_drive = 1'b1;
          first_d     = 1'b0;
          if (first_q || idx_q == IDX_WIDTH'(NUM_DIGITS - 1)) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else begin
          blank_cnt_d = blank_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Display only swaps at the frame boundary; a LOAD on that very cycle bypasses pending.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (LOAD) begin
      pend_val_d   = VALUE_IN;
      pend_dp_d    = DP_IN;
      pend_valid_d = 1'b1;
    end
    if (enter_drive && idx_d == '0) begin
      if (LOAD) begin
        disp_val_d   = VALUE_IN;
        disp_dp_d    = DP_IN;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        disp_val_d   = pend_val_q;
        disp_dp_d    = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  assign cur_nibble = disp_val_d[{idx_d, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] suppress;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    suppress   = '0;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (disp_val_d[k*4 +: 4] == 4'h0);
      suppress[k] = zero_above & ~disp_dp_d[k];
    end
  end
`endif

  // Outputs are computed from next-state values so the pins change on the same edge as the state.
  always_comb begin
    sel_d        = '1;
    hex_d        = SEG_BLANK;
    frame_done_d = 1'b0;
    if (state_d == DRIVE) begin
      sel_d[idx_d] = 1'b0;
      hex_d        = {~disp_dp_d[idx_d], cur_seg};
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
      if (suppress[idx_d]) begin
        hex_d = SEG_BLANK;
      end
`endif
      frame_done_d = enter_drive && (idx_d == IDX_WIDTH'(NUM_DIGITS - 1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      blank_cnt_q  <= '0;
      first_q      <= 1'b1;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      sel_q        <= '1;
      hex_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      blank_cnt_q  <= blank_cnt_d;
      first_q      <= first_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      sel_q        <= sel_d;
      hex_q        <= hex_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SEG_SELECT_OUT = sel_q;
  assign HEX_OUT        = hex_q;
  assign FRAME_DONE     = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (4 digits, 2 blank cycles).
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SCAN_TICK = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE_IN = '0;
  logic [3:0]  DP_IN = '0;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;
  logic        FRAME_DONE;

  int pass_cnt = 0;
  int total_cnt = 0;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .IDX_WIDTH    (2),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .SCAN_TICK      (SCAN_TICK),
    .LOAD           (LOAD),
    .VALUE_IN       (VALUE_IN),
    .DP_IN          (DP_IN),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .HEX_OUT        (HEX_OUT),
    .FRAME_DONE     (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sel, input logic [7:0] hex,
                         input logic fd);
    chk({tag, ".sel"}, {4'h0, SEG_SELECT_OUT}, {4'h0, sel});
    chk({tag, ".hex"}, HEX_OUT, hex);
    chk({tag, ".fd"}, {7'h0, FRAME_DONE}, {7'h0, fd});
  endtask

  // One scan tick: two blank cycles, then the drive of the next digit, then idle to ~20 cycles.
  task automatic scan(input string tag, input logic [3:0] sel, input logic [7:0] hex,
                      input logic fd, input logic bnd_load, input logic [15:0] v,
                      input logic [3:0] dp);
    SCAN_TICK = 1'b1;
    step();
    SCAN_TICK = 1'b0;
    chk_out({tag, ".blank0"}, 4'hF, 8'hFF, 1'b0);
    step();
    if (bnd_load) begin
      LOAD = 1'b1;
      VALUE_IN = v;
      DP_IN = dp;
    end
    chk_out({tag, ".blank1"}, 4'hF, 8'hFF, 1'b0);
    step();
    LOAD = 1'b0;
    chk_out({tag, ".drive"}, sel, hex, fd);
    step();
    chk_out({tag, ".hold"}, sel, hex, 1'b0);
    repeat (15) step();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    LOAD = 1'b1;
    VALUE_IN = v;
    DP_IN = dp;
    step();
    LOAD = 1'b0;
  endtask

  initial begin
    // Reset and long quiet period
    repeat (3) step();
    chk_out("in_reset", 4'hF, 8'hFF, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk_out("idle", 4'hF, 8'hFF, 1'b0);
    end

    // First frame of 12AF
    load(16'h12AF, 4'h0);
    scan("f1d0", 4'hE, 8'h8E, 1'b0, 1'b0, '0, '0);
    scan("f1d1", 4'hD, 8'h88, 1'b0, 1'b0, '0, '0);
    scan("f1d2", 4'hB, 8'hA4, 1'b0, 1'b0, '0, '0);
    scan("f1d3", 4'h7, 8'hF9, 1'b1, 1'b0, '0, '0);

    // Mid-frame load only takes effect at next digit 0
    scan("f2d0", 4'hE, 8'h8E, 1'b0, 1'b0, '0, '0);
    scan("f2d1", 4'hD, 8'h88, 1'b0, 1'b0, '0, '0);
    load(16'h1111, 4'h0);
    chk_out("f2d1_after_load", 4'hD, 8'h88, 1'b0);
    scan("f2d2", 4'hB, 8'hA4, 1'b0, 1'b0, '0, '0);
    scan("f2d3", 4'h7, 8'hF9, 1'b1, 1'b0, '0, '0);
    scan("f3d0", 4'hE, 8'hF9, 1'b0, 1'b0, '0, '0);
    scan("f3d1", 4'hD, 8'hF9, 1'b0, 1'b0, '0, '0);
    scan("f3d2", 4'hB, 8'hF9, 1'b0, 1'b0, '0, '0);
    scan("f3d3", 4'h7, 8'hF9, 1'b1, 1'b0, '0, '0);

    // LOAD coincident with boundary: 5 with dp on digit 0 shows immediately
    scan("f4d0", 4'hE, 8'h12, 1'b0, 1'b1, 16'h0005, 4'h1);
    scan("f4d1", 4'hD, 8'hC0, 1'b0, 1'b0, '0, '0);

    // Tick during blank is ignored
    SCAN_TICK = 1'b1;
    step();
    chk_out("dbl.blank0", 4'hF, 8'hFF, 1'b0);
    step();
    SCAN_TICK = 1'b0;
    chk_out("dbl.blank1", 4'hF, 8'hFF, 1'b0);
    step();
    chk_out("dbl.drive", 4'hB, 8'hC0, 1'b0);
    repeat (3) step();
    chk_out("dbl.hold", 4'hB, 8'hC0, 1'b0);
    repeat (12) step();
    scan("f4d3", 4'h7, 8'hC0, 1'b1, 1'b0, '0, '0);

    // Leading-zero vector 0040
    load(16'h0040, 4'h0);
    scan("lz_d0", 4'hE, 8'hC0, 1'b0, 1'b0, '0, '0);
    scan("lz_d1", 4'hD, 8'h99, 1'b0, 1'b0, '0, '0);
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
    scan("lz_d2", 4'hB, 8'hFF, 1'b0, 1'b0, '0, '0);
    scan("lz_d3", 4'h7, 8'hFF, 1'b1, 1'b0, '0, '0);
`else
    scan("lz_d2", 4'hB, 8'hC0, 1'b0, 1'b0, '0, '0);
    scan("lz_d3", 4'h7, 8'hC0, 1'b1, 1'b0, '0, '0);
`endif

    // Reset mid-operation discards pending data
    scan("pre_rst_d0", 4'hE, 8'hC0, 1'b0, 1'b0, '0, '0);
    load(16'h7777, 4'hF);
    RESET = 1'b1;
    step();
    chk_out("mid_reset", 4'hF, 8'hFF, 1'b0);
    RESET = 1'b0;
    step();
    chk_out("post_reset", 4'hF, 8'hFF, 1'b0);
    scan("rst_d0", 4'hE, 8'hC0, 1'b0, 1'b0, '0, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
